// File: rtl/ser_instream.sv
// RS232 8N1 receiver that packs received bytes into a 128-bit block with a valid/ack handshake.
// Optional HEX_ASCII_EN: each ASCII hex digit received contributes one nibble; other bytes are ignored.
module ser_instream #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rs232rx,
    input  logic         ack,
    output logic [127:0] block,
    output logic         valid,
    output logic         frame_err,
    output logic         overrun
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int TW       = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          rx_meta, rx_sync;
    logic          byte_ok;
    logic          frame_bad;

    // Synchronizer resets to the idle-line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rs232rx;
            rx_sync <= rx_meta;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        timer_next   = timer + TW'(1);
        bit_idx_next = bit_idx;
        shift_next   = shift;
        byte_ok      = 1'b0;
        frame_bad    = 1'b0;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (!rx_sync) state_next = START;
            end
            START: begin
                if (timer == TW'(HALF_BIT - 1)) begin
                    timer_next   = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == TW'(CLKS_PER_BIT - 1)) begin
                    timer_next   = '0;
                    shift_next   = {rx_sync, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (timer == TW'(CLKS_PER_BIT - 1)) begin
                    timer_next = '0;
                    state_next = IDLE;
                    byte_ok    = rx_sync;
                    frame_bad  = !rx_sync;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef HEX_ASCII_EN
    localparam int SLOT_W = 4;

    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
        if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        return 5'd0;
    endfunction

    logic [4:0] hex_dec;
    assign hex_dec = hex_decode(shift);
`else
    localparam int SLOT_W = 8;
`endif

    localparam int SLOTS = 128 / SLOT_W;
    localparam int CW    = $clog2(SLOTS);

    logic [SLOT_W-1:0] slot_data;
    logic              slot_take;
    logic [CW-1:0]     slot_cnt;
    logic [6:0]        slot_base;

`ifdef HEX_ASCII_EN
    assign slot_data = hex_dec[3:0];
    assign slot_take = byte_ok && hex_dec[4];
`else
    assign slot_data = shift;
    assign slot_take = byte_ok;
`endif

    // Slot 0 is the most significant slot of the block.
    assign slot_base = 7'((SLOTS - 1 - int'(slot_cnt)) * SLOT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            block     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            slot_cnt  <= '0;
        end else begin
            frame_err <= frame_bad;
            if (frame_bad) slot_cnt <= '0;
            if (ack && valid) valid <= 1'b0;
            if (slot_take) begin
                if (valid) begin
                    overrun <= 1'b1;
                end else begin
                    block[slot_base +: SLOT_W] <= slot_data;
                    if (slot_cnt == CW'(SLOTS - 1)) begin
                        slot_cnt <= '0;
                        valid    <= 1'b1;
                    end else begin
                        slot_cnt <= slot_cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ser_instream.sv
// Scoreboard bench for ser_instream: stimulus pushes expected blocks / frame errors, a monitor pops and compares.
module tb_ser_instream;

    localparam int CPB = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rs232rx = 1'b1;
    logic         ack = 1'b0;
    logic [127:0] block;
    logic         valid;
    logic         frame_err;
    logic         overrun;

    int tests = 0;
    int fails = 0;

    logic [127:0] blk_q[$];
    bit           ferr_q[$];
    logic [127:0] exp_blk;
    logic         valid_prev = 1'b0;
    logic         ferr_prev = 1'b0;

    always #5 clk = ~clk;

    ser_instream #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs232rx  (rs232rx),
        .ack      (ack),
        .block    (block),
        .valid    (valid),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_level);
        rs232rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rs232rx = b[i];
            tick(CPB);
        end
        rs232rx = stop_level;
        tick(CPB);
        rs232rx = 1'b1;
        tick(stop_level ? 2 : 2 * CPB);
    endtask

    task automatic send_bytes(input logic [127:0] vec, input int first, input int count);
        for (int i = first; i < first + count; i++) send_byte(vec[127 - 8 * i -: 8], 1'b1);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!valid && k < 8 * CPB) begin
            tick(1);
            k++;
        end
        check(name, valid, 1'b1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    // Monitor: compares every block presentation and frame-error pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            valid_prev <= 1'b0;
            ferr_prev  <= 1'b0;
        end else begin
            if (valid && !valid_prev) begin
                check("block_expected", blk_q.size() > 0, 1'b1);
                if (blk_q.size() > 0) begin
                    exp_blk = blk_q.pop_front();
                    check("block_data", block, exp_blk);
                    check("overrun_at_block", overrun, 1'b0);
                end
            end
            if (frame_err) begin
                check("ferr_expected", ferr_q.size() > 0, 1'b1);
                if (ferr_q.size() > 0) void'(ferr_q.pop_front());
                check("ferr_one_cycle", ferr_prev, 1'b0);
            end
            valid_prev <= valid;
            ferr_prev  <= frame_err;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] v_text;
        logic [127:0] v_alt;
        logic [127:0] v_seq;
        v_text = 128'h0a4d44352072656164790a486173683a;
        v_alt  = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        v_seq  = 128'h000102030405060708090a0b0c0d0e0f;

        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_valid", valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_block", block, 128'h0);
        tick(2 * CPB);

`ifdef HEX_ASCII_EN
        v_text = "0123456789abcdef";
        blk_q.push_back(128'h0123456789abcdef0123456789abcdef);
        send_bytes(v_text, 0, 16);
        send_byte(8'h0a, 1'b1);
        send_bytes(v_text, 0, 16);
        wait_valid("hex_valid");
        pulse_ack();
        check("hex_ack_clears", valid, 1'b0);
`else
        // Text block with a short low glitch in the middle of it.
        blk_q.push_back(v_text);
        send_bytes(v_text, 0, 5);
        rs232rx = 1'b0;
        tick(CPB / 4);
        rs232rx = 1'b1;
        tick(2 * CPB);
        check("glitch_no_ferr_pending", ferr_q.size(), 0);
        send_bytes(v_text, 5, 11);
        wait_valid("text_valid");
        pulse_ack();
        check("text_ack_clears", valid, 1'b0);
        check("text_block_retained", block, v_text);

        // Three bytes, a bad stop bit, then a clean block of 16.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        ferr_q.push_back(1'b1);
        send_byte(8'h55, 1'b0);
        check("ferr_consumed", ferr_q.size(), 0);
        blk_q.push_back(v_alt);
        send_bytes(v_alt, 0, 16);
        wait_valid("alt_valid");

        // Extra byte while the block is still held.
        send_byte(8'hff, 1'b1);
        tick(2);
        check("overrun_set", overrun, 1'b1);
        check("overrun_valid_held", valid, 1'b1);
        check("overrun_block_unchanged", block, v_alt);
        pulse_ack();
        check("overrun_ack_clears", valid, 1'b0);
        check("overrun_sticky", overrun, 1'b1);

        // Seven bytes plus a partial frame, then reset mid-byte.
        for (int i = 0; i < 7; i++) send_byte(8'ha0 + 8'(i), 1'b1);
        rs232rx = 1'b0;
        tick(3 * CPB);
        rs232rx = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_overrun", overrun, 1'b0);
        check("rst_block", block, 128'h0);
        check("rst_valid", valid, 1'b0);
        tick(2 * CPB);
        blk_q.push_back(v_seq);
        send_bytes(v_seq, 0, 16);
        wait_valid("seq_valid");
        pulse_ack();
        check("seq_ack_clears", valid, 1'b0);
        check("seq_no_overrun", overrun, 1'b0);
`endif

        tick(4);
        check("blocks_all_seen", blk_q.size(), 0);
        check("ferr_all_seen", ferr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
